// File: rtl/inst_ram_loader.sv
// inst_ram_loader: writable fetch-stage instruction store with a framed byte-stream loader.
// Frame format: [N][4*N data bytes, big-endian words][XOR checksum].
// Words land at word addresses 1..N. Address 0 always reads as a NOP (zero).
// The CPU is stalled while a frame is in flight or after a rejected frame.
module inst_ram_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] a,
  output logic [31:0]       inst,
  output logic              cpu_stall,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-1:0] word_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LOAD = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [7:0]        MAX_N   = 8'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ZERO_A  = {ADDR_W{1'b0}};

  state_t            state_r, state_s;
  logic [31:0]       mem_r [DEPTH];
  logic [ADDR_W-1:0] n_words_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] word_cnt_r;
  logic [1:0]        byte_cnt_r;
  logic [23:0]       word_buf_r;
  logic [7:0]        chk_r;

  logic              xfer_s;
  logic              start_s;
  logic              hdr_ok_s;
  logic              last_word_s;

  // Running checksum of the frame payload: XOR of every data byte.
  function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
    chk_next = acc ^ b;
  endfunction

  assign xfer_s      = byte_valid & byte_ready;
  // A new frame may only be opened from a resting state; mid-frame requests are ignored.
  assign start_s     = load_start & ((state_r == IDLE) | (state_r == DONE) | (state_r == ERR));
  // N must leave address 0 untouched and fit the remaining DEPTH-1 words without wrapping.
  assign hdr_ok_s    = (byte_in != 8'd0) && (byte_in <= MAX_N);
  assign last_word_s = (word_cnt_r == (n_words_r - ONE_A));

  assign byte_ready  = (state_r == HDR) | (state_r == LOAD) | (state_r == CHK);
  assign cpu_stall   = (state_r == HDR) | (state_r == LOAD) | (state_r == CHK) | (state_r == ERR);
  assign load_done   = (state_r == DONE);
  assign load_err    = (state_r == ERR);
  assign word_cnt    = word_cnt_r;

  // Fetch port: NOP while stalled and at address 0, otherwise the stored word.
  always_comb begin
    inst = 32'h0000_0000;
    if (cpu_stall || (a == ZERO_A)) begin
      inst = 32'h0000_0000;
    end else begin
      inst = mem_r[a];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_start) state_s = HDR;
        else            state_s = IDLE;
      end
      HDR: begin
        if (xfer_s) state_s = hdr_ok_s ? LOAD : ERR;
        else        state_s = HDR;
      end
      LOAD: begin
        if (xfer_s && (byte_cnt_r == 2'd3) && last_word_s) state_s = CHK;
        else                                               state_s = LOAD;
      end
      CHK: begin
        if (xfer_s) state_s = (byte_in == chk_r) ? DONE : ERR;
        else        state_s = CHK;
      end
      DONE, ERR: begin
        if (load_start) state_s = HDR;
        else            state_s = state_r;
      end
      default: state_s = IDLE;
    endcase
  end

  // Frame datapath: header capture, word packing, RAM write, checksum accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 32'h0000_0000;
      n_words_r  <= ZERO_A;
      addr_r     <= ZERO_A;
      word_cnt_r <= ZERO_A;
      byte_cnt_r <= 2'd0;
      word_buf_r <= 24'h00_0000;
      chk_r      <= 8'h00;
    end else if (start_s) begin
      addr_r     <= ONE_A;
      word_cnt_r <= ZERO_A;
      byte_cnt_r <= 2'd0;
      word_buf_r <= 24'h00_0000;
      chk_r      <= 8'h00;
    end else if (xfer_s) begin
      case (state_r)
        HDR: begin
          n_words_r <= byte_in[ADDR_W-1:0];
        end
        LOAD: begin
          chk_r <= chk_next(chk_r, byte_in);
          if (byte_cnt_r == 2'd3) begin
            mem_r[addr_r] <= {word_buf_r, byte_in};
            word_cnt_r    <= word_cnt_r + ONE_A;
            byte_cnt_r    <= 2'd0;
            // Hold the address on the final word so it never steps past DEPTH-1.
            if (!last_word_s) addr_r <= addr_r + ONE_A;
            else              addr_r <= addr_r;
          end else begin
            word_buf_r <= {word_buf_r[15:0], byte_in};
            byte_cnt_r <= byte_cnt_r + 2'd1;
          end
        end
        default: begin
          chk_r <= chk_r;
        end
      endcase
    end
  end

endmodule
